if_fetch_unit: RTL and testbench

// Instruction-fetch front end: the producer side of the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end (producer side of the IF/ID register).
// Holds the PC and issues in-order requests to instruction memory.
// Returned words are buffered with their PCs in a 2-entry queue.
// The head of the queue is offered to decode under valid/ready.
// A redirect flushes the queue and discards responses that are still in flight.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_req/addr/gnt   fetch request, address (= PC), accept strobe
//   imem_rvalid/rdata   in-order fetch responses
//   redirect_valid/pc   flush and restart fetch at redirect_pc
//   inst_valid/ready    head-of-queue handshake toward IF/ID (ready low = stall)
//   instruction/inst_pc head word and its PC; both zero when the queue is empty
//   err_unexpected      sticky flag: a response arrived with nothing outstanding
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        err_unexpected
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;  // holds 0..DEPTH
  localparam int unsigned OW    = 3;  // occupancy sum needs one extra bit

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     kill_q, kill_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   q_word_q [DEPTH];
  logic [XLEN-1:0]   q_word_d [DEPTH];
  logic [XLEN-1:0]   q_pc_q   [DEPTH];
  logic [XLEN-1:0]   q_pc_d   [DEPTH];
  logic [XLEN-1:0]   tag_q    [DEPTH];
  logic [XLEN-1:0]   tag_d    [DEPTH];

  logic              pop;
  logic              grant;
  logic              rsp_ok;
  logic              unexpected;
  logic [OW-1:0]     occ;
  logic              q_wr_idx;
  logic              tag_wr_idx;

  // Handshake decode
  assign pop        = inst_valid & inst_ready;
  assign rsp_ok     = imem_rvalid & (outst_q != '0);
  assign unexpected = imem_rvalid & (outst_q == '0);

  // Slots already committed: queued words plus requests in flight. A pop in the
  // same cycle frees a slot, which keeps a 1-cycle memory streaming without gaps.
  assign occ      = OW'(cnt_q) + OW'(outst_q) - OW'(pop);
  assign imem_req = (state_q == S_RUN) & ~redirect_valid & (occ < OW'(DEPTH));
  assign grant    = imem_req & imem_gnt;

  // Write slots account for a same-cycle shift out of entry 0
  assign q_wr_idx   = 1'(cnt_q - CW'(pop));
  assign tag_wr_idx = 1'(outst_q - CW'(rsp_ok));

  // Outputs are straight from registered state
  assign imem_addr      = pc_q;
  assign inst_valid     = (cnt_q != '0);
  assign instruction    = inst_valid ? q_word_q[0] : '0;
  assign inst_pc        = inst_valid ? q_pc_q[0] : '0;
  assign err_unexpected = err_q;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    outst_d  = outst_q;
    kill_d   = kill_q;
    err_d    = err_q | unexpected;
    q_word_d = q_word_q;
    q_pc_d   = q_pc_q;
    tag_d    = tag_q;

    if (redirect_valid) begin
      // Everything in flight becomes stale; req is low so no grant adds to it
      pc_d    = redirect_pc;
      cnt_d   = '0;
      outst_d = outst_q - CW'(rsp_ok);
      kill_d  = outst_q - CW'(rsp_ok);
      state_d = ((outst_q - CW'(rsp_ok)) != '0) ? S_FLUSH : S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (grant) begin
            pc_d              = pc_q + XLEN'(PC_STEP);
            tag_d[tag_wr_idx] = pc_q;
          end
          if (rsp_ok) begin
            tag_d[0] = tag_q[1];
            if (!grant || tag_wr_idx != 1'b0) tag_d[0] = tag_q[1];
          end
          if (grant && rsp_ok && tag_wr_idx == 1'b0) tag_d[0] = pc_q;
          outst_d = outst_q + CW'(grant) - CW'(rsp_ok);

          if (pop) begin
            q_word_d[0] = q_word_q[1];
            q_pc_d[0]   = q_pc_q[1];
          end
          if (rsp_ok) begin
            q_word_d[q_wr_idx] = imem_rdata;
            q_pc_d[q_wr_idx]   = tag_q[0];
          end
          cnt_d = cnt_q + CW'(rsp_ok) - CW'(pop);
        end
        S_FLUSH: begin
          // Stale responses are dropped; fetch resumes once the last one is gone
          if (rsp_ok) begin
            outst_d = outst_q - CW'(1);
            kill_d  = kill_q - CW'(1);
            if (kill_q == CW'(1)) state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      outst_q  <= '0;
      kill_q   <= '0;
      err_q    <= 1'b0;
      q_word_q <= '{default: '0};
      q_pc_q   <= '{default: '0};
      tag_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      q_word_q <= q_word_d;
      q_pc_q   <= q_pc_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit.
// A memory model answers granted fetches in order after a programmable latency.
// A scoreboard expects decode to see PCs start, start+4, ... after each reset or
// redirect, each word equal to its address XOR a key, with fetch gated while
// stale responses are still due.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        err_unexpected;

  if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .inst_pc        (inst_pc),
    .err_unexpected (err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int n_acc;
  int cyc;
  int gnt_mode;   // 0 low, 1 high, 2 random
  int lat_min;
  int lat_max;
  bit force_rv;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } pend_t;
  pend_t       pend[$];
  pend_t       pe;
  int          epoch;
  int          stale;
  logic [31:0] exp_inst;
  logic [31:0] exp_fetch;
  bit          exp_err;

  // Memory model plus stream scoreboard; samples on the falling edge
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    epoch = 0; exp_inst = RST_PC; exp_fetch = RST_PC; exp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        n_cmp++;
        if (err_unexpected !== exp_err) begin
          n_fail++; $display("FAIL mon_err: got %0b expected %0b t=%0t", err_unexpected, exp_err, $time);
        end
        if (inst_valid) begin
          n_cmp++;
          if (inst_pc !== exp_inst || instruction !== (exp_inst ^ KEY)) begin
            n_fail++; $display("FAIL mon_head: pc %h word %h expected pc %h word %h t=%0t",
                               inst_pc, instruction, exp_inst, exp_inst ^ KEY, $time);
          end
          if (inst_ready) begin exp_inst = exp_inst + 32'd4; n_acc++; end
        end else begin
          n_cmp++;
          if (instruction !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++; $display("FAIL mon_empty: word %h pc %h expected 0 t=%0t", instruction, inst_pc, $time);
          end
        end
        if (stale > 0 || redirect_valid) begin
          n_cmp++;
          if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL mon_req_gate: req %0b expected 0 (stale %0d) t=%0t", imem_req, stale, $time);
          end
        end
        if (imem_rvalid) begin
          if (pend.size() > 0) void'(pend.pop_front());
          else exp_err = 1'b1;
        end
        if (imem_req && imem_gnt) begin
          n_cmp++;
          if (imem_addr !== exp_fetch) begin
            n_fail++; $display("FAIL mon_fetch: addr %h expected %h t=%0t", imem_addr, exp_fetch, $time);
          end
          pe.addr = imem_addr; pe.due = cyc + int'($urandom_range(lat_max, lat_min)); pe.epoch = epoch;
          pend.push_back(pe);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
          exp_inst = redirect_pc; exp_fetch = redirect_pc; epoch++;
        end
      end else begin
        pend.delete(); exp_inst = RST_PC; exp_fetch = RST_PC; exp_err = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      case (gnt_mode)
        0:       imem_gnt = 1'b0;
        1:       imem_gnt = 1'b1;
        default: imem_gnt = ($urandom_range(3, 0) != 0);
      endcase
      if (force_rv) begin
        imem_rvalid = 1'b1; imem_rdata = $urandom;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1; imem_rdata = pend[0].addr ^ KEY;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0; force_rv = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    gnt_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || instruction !== 32'h0 || inst_pc !== 32'h0 ||
        err_unexpected !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_state: valid %0b word %h pc %h err %0b addr %h", inst_valid,
                         instruction, inst_pc, err_unexpected, imem_addr);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_first_req: req %0b addr %h expected 1 %h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int first_g = -1;
    int first_v = -1;
    int gaps = 0;
    gnt_mode = 1; lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && first_g < 0) first_g = c;
      if (inst_valid && first_v < 0) begin
        first_v = c;
        n_cmp++;
        if (inst_pc !== RST_PC) begin
          n_fail++; $display("FAIL stream_first_pc: got %h expected %h", inst_pc, RST_PC);
        end
      end else if (first_v >= 0 && !inst_valid) gaps++;
    end
    n_cmp++;
    if (first_g < 0 || first_v - first_g != 2) begin
      n_fail++; $display("FAIL stream_latency: grant at %0d valid at %0d expected 2 apart", first_g, first_v);
    end
    n_cmp++;
    if (gaps != 0) begin
      n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps);
    end
  endtask

  task automatic test_stall();
    int gaps = 0;
    int acc0;
    @(posedge clk); #1; inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0 || pend.size() != 0) begin
      n_fail++; $display("FAIL stall_full: valid %0b req %0b outstanding %0d expected 1 0 0",
                         inst_valid, imem_req, pend.size());
    end
    @(posedge clk); #1; inst_ready = 1'b1; acc0 = n_acc;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!inst_valid) gaps++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (gaps != 0 || n_acc - acc0 != 10) begin
      n_fail++; $display("FAIL stall_resume: gaps %0d accepted %0d expected 0 10", gaps, n_acc - acc0);
    end
  endtask

  task automatic test_redirect();
    bit got = 1'b0;
    bit seen = 1'b0;
    gnt_mode = 1; lat_min = 4; lat_max = 4; inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (pend.size() == 2) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++; $display("FAIL redir_setup: outstanding %0d expected 2", pend.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++; $display("FAIL redir_req: got %0b expected 0", imem_req);
    end
    @(posedge clk); #1; redirect_valid = 1'b0; lat_min = 1; lat_max = 1;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_flush: valid %0b req %0b addr %h expected 0 0 00000100",
                         inst_valid, imem_req, imem_addr);
    end
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (inst_pc !== 32'h100 || instruction !== (32'h100 ^ KEY)) begin
          n_fail++; $display("FAIL redir_first: pc %h word %h expected 00000100 %h", inst_pc, instruction, 32'h100 ^ KEY);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL redir_timeout: got no inst_valid expected one within 40 cycles");
    end
  endtask

  task automatic test_gnt_stall();
    gnt_mode = 0; lat_min = 1; lat_max = 1; inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
        n_fail++; $display("FAIL gnt_hold: cycle %0d req %0b addr %h expected 1 %h", c, imem_req, imem_addr, RST_PC);
      end
    end
    gnt_mode = 1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_gnt !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL gnt_accept: req %0b gnt %0b addr %h expected 1 1 %h", imem_req, imem_gnt, imem_addr, RST_PC);
    end
    gnt_mode = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'd4) begin
        n_fail++; $display("FAIL gnt_step: cycle %0d req %0b addr %h expected 1 %h", c, imem_req, imem_addr, RST_PC + 32'd4);
      end
    end
  endtask

  task automatic test_unexpected();
    gnt_mode = 0; inst_ready = 1'b1;
    do_reset();
    @(negedge clk); force_rv = 1'b1;
    @(negedge clk); force_rv = 1'b0;
    n_cmp++;
    if (imem_rvalid !== 1'b1 || err_unexpected !== 1'b0) begin
      n_fail++; $display("FAIL unexp_pre: rvalid %0b err %0b expected 1 0", imem_rvalid, err_unexpected);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (err_unexpected !== 1'b1 || inst_valid !== 1'b0) begin
        n_fail++; $display("FAIL unexp_sticky: cycle %0d err %0b valid %0b expected 1 0", c, err_unexpected, inst_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    gnt_mode = 1;
    @(posedge clk); #1; lat_min = 1; lat_max = 1; inst_ready = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0 || err_unexpected !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: valid %0b req %0b err %0b expected 1 0 1", inst_valid, imem_req, err_unexpected);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_valid !== 1'b0 || instruction !== 32'h0 || inst_pc !== 32'h0 ||
        err_unexpected !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++; $display("FAIL rstmid_clear: valid %0b word %h pc %h err %0b addr %h", inst_valid,
                         instruction, inst_pc, err_unexpected, imem_addr);
    end
    @(posedge clk); #1; inst_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (inst_pc !== RST_PC) begin
          n_fail++; $display("FAIL rstmid_restart: pc %h expected %h", inst_pc, RST_PC);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++; $display("FAIL rstmid_timeout: got no inst_valid expected one within 10 cycles");
    end
  endtask

  task automatic test_random();
    int acc0;
    gnt_mode = 2; lat_min = 1; lat_max = 3; inst_ready = 1'b1;
    do_reset();
    acc0 = n_acc;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      inst_ready = ($urandom_range(9, 0) < 7);
      if ($urandom_range(39, 0) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF8;
        else redirect_pc = $urandom & 32'hFFFF_FFFC;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (n_acc - acc0 < 300) begin
      n_fail++; $display("FAIL random_progress: accepted %0d expected at least 300", n_acc - acc0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_fail = 0; n_acc = 0; cyc = 0;
    gnt_mode = 0; lat_min = 1; lat_max = 1; force_rv = 1'b0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_gnt_stall();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
